fifo_wr_arbiter: RTL and testbench

- Shares one synchronous FIFO write port among NUM_REQ producers using round-robin arbitration with bounded bursts.
- Sits directly in front of the FIFO's write side. It drives the FIFO's wr_en and data_in and observes its full flag.
- Each producer uses a valid/ready handshake. A producer holds the write port for up to MAX_BURST words, or until it marks its last word, whichever comes first.

---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_if.sv | 37 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared state type, id-width helper and default sizing for the FIFO write-port arbiter.
// Used by fifo_wr_arbiter, its interface and the rr_pick round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  // Index width for n producers; never collapses to zero bits.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request bundle plus FIFO write-side signals around fifo_wr_arbiter.
// With FIFO_ARB_TAG_EN defined, fifo_data_in carries {grant_id, data}.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = fifo_arb_pkg::DEF_NUM_REQ,
  parameter int DATA_WIDTH = fifo_arb_pkg::DEF_DATA_WIDTH
);
  import fifo_arb_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);
`ifdef FIFO_ARB_TAG_EN
  localparam int WORD_W = DATA_WIDTH + ID_W;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [WORD_W-1:0]             fifo_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  // master: producers plus the FIFO side; slave: the arbiter itself
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after last_grant, wrapping at NUM_REQ.
// Zero latency; found=0 when no bit of valid is set.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // Explicit subtract instead of % keeps non-power-of-two NUM_REQ free of a divider.
  function automatic int wrap_idx(input int base, input int off);
    int c;
    c = base + off;
    if (c >= NUM_REQ) c = c - NUM_REQ;
    return c;
  endfunction

  // Scan farthest offset first so the nearest valid index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (valid[wrap_idx(int'(last_grant), off)]) begin
        idx   = ID_W'(wrap_idx(int'(last_grant), off));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of one FIFO write port: 1-cycle arbitration in IDLE, then up to MAX_BURST single-cycle writes.
// fifo_full drops the owner's ready and stalls the burst in place; an owner that goes invalid loses the port. Macro: FIFO_ARB_TAG_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rstn,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MAX_BURST - 1);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_found;
  logic                  own_valid;
  logic                  own_last;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid      (bus.req_valid),
    .last_grant (last_q),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  assign own_valid = bus.req_valid[grant_q];
  assign own_last  = bus.req_last[grant_q];
  assign own_data  = bus.req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id = grant_q;

`ifdef FIFO_ARB_TAG_EN
  assign bus.fifo_data_in = {grant_q, own_data};
`else
  assign bus.fifo_data_in = own_data;
`endif

  // last_grant resets to NUM_REQ-1 so producer 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    xfer           = 1'b0;
    bus.req_ready  = '0;
    bus.fifo_wr_en = 1'b0;
    bus.busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          grant_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        bus.busy               = 1'b1;
        bus.req_ready[grant_q] = !bus.fifo_full;
        xfer                   = own_valid && !bus.fifo_full;
        bus.fifo_wr_en         = xfer;
        if (!own_valid) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (own_last || (cnt_q == CNT_END)) state_d = IDLE;
          else                                cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.fifo_wr_en && bus.fifo_full));

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, max-length bursts, req_last, fifo_full stall, valid drop, mid-burst reset, tag format.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = id_w(N);
`ifdef FIFO_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] en;
  int           wcnt[N];
  int           blen[N];

  logic           o_we, o_busy;
  logic [N-1:0]   o_rdy;
  logic [IDW-1:0] o_gid;
  logic [31:0]    o_dat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int id, input logic [7:0] d);
    return TAG ? ((32'(id) << DW) | 32'(d)) : 32'(d);
  endfunction

  // Producer i presents {i, word_count}; req_last marks the end of each blen-word burst.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW] = {4'(i), 4'(wcnt[i])};
      bus.req_last[i] = (blen[i] != 0) && ((wcnt[i] % blen[i]) == (blen[i] - 1));
    end
    bus.req_valid = en;
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0;
      blen[i] = 0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    o_we   = bus.fifo_wr_en;
    o_busy = bus.busy;
    o_rdy  = bus.req_ready;
    o_gid  = bus.grant_id;
    o_dat  = 32'(bus.fifo_data_in);
    hs     = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) wcnt[i]++;
    drive();
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_we"}, 32'(o_we), 32'd0);
  endtask

  task automatic expect_write(input string tag, input int id, input logic [7:0] d);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
    check_eq({tag, "_gid"}, 32'(o_gid), 32'(id));
    check_eq({tag, "_we"}, 32'(o_we), 32'd1);
    check_eq({tag, "_rdy"}, 32'(o_rdy), 32'd1 << id);
    check_eq({tag, "_dat"}, o_dat, word(id, d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[5];
    int ew[N];
    order = '{0, 1, 2, 3, 0};

    en = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    clr();
    drive();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_we", 32'(bus.fifo_wr_en), 32'd0);
    check_eq("rst_rdy", 32'(bus.req_ready), 32'd0);
    check_eq("rst_gid", 32'(bus.grant_id), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Producers 1 and 3: producer 1 wins, runs MAX_BURST words, then 3 takes over.
    en = 4'b1010;
    drive();
    cycle(); expect_idle("t1_arb");
    for (int k = 0; k < MB; k++) begin
      cycle(); expect_write("t1_w", 1, 8'(8'h10 + k));
    end
    cycle(); expect_idle("t1_gap");
    cycle(); expect_write("t1_next", 3, 8'h30);
    en = '0; drive();
    cycle(); check_eq("t1_rel_we", 32'(o_we), 32'd0);
    cycle(); expect_idle("t1_end");

    // All valid, 2-word bursts ended by req_last: grants rotate 0,1,2,3,0.
    clr();
    for (int i = 0; i < N; i++) begin
      blen[i] = 2;
      ew[i]   = 0;
    end
    en = 4'b1111;
    drive();
    for (int g = 0; g < 5; g++) begin
      cycle(); expect_idle("t2_arb");
      for (int j = 0; j < 2; j++) begin
        cycle(); expect_write("t2_w", order[g], {4'(order[g]), 4'(ew[order[g]])});
        ew[order[g]]++;
      end
    end
    en = '0; drive();
    cycle(); expect_idle("t2_end");

    // Producer 2 stalled by fifo_full for 3 cycles after its first word.
    clr();
    en = 4'b0100;
    drive();
    cycle(); expect_idle("t3_arb");
    cycle(); expect_write("t3_w0", 2, 8'h20);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("t3_full_we", 32'(o_we), 32'd0);
      check_eq("t3_full_rdy", 32'(o_rdy), 32'd0);
      check_eq("t3_full_busy", 32'(o_busy), 32'd1);
    end
    bus.fifo_full = 1'b0;
    for (int k = 1; k < MB; k++) begin
      cycle(); expect_write("t3_w", 2, 8'(8'h20 + k));
    end
    en = '0; drive();
    cycle(); expect_idle("t3_end");

    // Producer 0 drops valid after one word; producer 2 is next even though 0 re-requests.
    clr();
    en = 4'b0101;
    drive();
    cycle(); expect_idle("t4_arb");
    cycle(); expect_write("t4_w0", 0, 8'h00);
    en = 4'b0100; drive();
    cycle();
    check_eq("t4_drop_we", 32'(o_we), 32'd0);
    check_eq("t4_drop_busy", 32'(o_busy), 32'd1);
    en = 4'b0101; drive();
    cycle(); expect_idle("t4_gap");
    cycle(); expect_write("t4_next", 2, 8'h20);
    en = '0; drive();
    cycle();
    cycle(); expect_idle("t4_end");

    // Reset during producer 1's second word; afterwards producer 0 beats producer 3.
    clr();
    en = 4'b0010;
    drive();
    cycle(); expect_idle("t5_arb");
    cycle(); expect_write("t5_w0", 1, 8'h10);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    clr();
    en = 4'b1001; drive();
    cycle();
    expect_idle("t5_rst");
    check_eq("t5_rst_gid", 32'(o_gid), 32'd0);
    cycle(); expect_write("t5_prio", 0, 8'h00);
    en = '0; drive();
    cycle();
    cycle(); expect_idle("t5_end");

    // Producer 3 writes 8'hA5; tagged builds carry the source id above the data.
    clr();
    en = 4'b1000;
    drive();
    cycle(); expect_idle("t6_arb");
    bus.req_data[3*DW +: DW] = 8'hA5;
    cycle();
    check_eq("t6_we", 32'(o_we), 32'd1);
    check_eq("t6_dat", o_dat, TAG ? 32'h3A5 : 32'hA5);
    en = '0; drive();
    cycle();
    cycle(); expect_idle("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
